mem_arbiter: RTL and testbench

- Sequences the single-port unified instruction/data memory of the multi-cycle MIPS core.
- Shares the memory between two requesters: the instruction-fetch path (read only) and the load/store path (read/write).
- Each access is a req/ready handshake with a configurable wait-state count, so slower memory models can be introduced later without touching the controller.
- Sits between the core's fetch/memory stages and the memory array; it is the only driver of the memory's we/a/wd inputs.

---
 rtl/mem_arb_pkg.sv | 18 +
 rtl/mem_arbiter_rr_arb2.sv | 23 ++
 rtl/mem_arbiter.sv | 126 ++++++++++++
 tb/tb_mem_arbiter.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory arbiter: FSM states, requester ids and
// the wait-state counter width.
package mem_arb_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  typedef enum logic {
    REQ_IF = 1'b0,
    REQ_D  = 1'b1
  } req_id_t;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin picker. On a tie the requester that did not win last
// time is chosen.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic    req_if,
  input  logic    req_d,
  input  req_id_t last_grant,
  output logic    grant_valid,
  output req_id_t grant_id
);

  always_comb begin
    grant_valid = req_if | req_d;
    grant_id    = REQ_IF;
    if (req_if && req_d) begin
      grant_id = (last_grant == REQ_IF) ? REQ_D : REQ_IF;
    end else if (req_d) begin
      grant_id = REQ_D;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Sequences the single-port instruction/data memory between the fetch and
// load/store paths: IDLE -> ACCESS (WAIT_CYCLES+1 cycles) -> DONE.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ready,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ready,
  output logic [31:0] d_rdata,
  output logic        mem_we,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd,
  output logic        busy
);

  state_t           state_q, state_d;
  req_id_t          last_grant_q, last_grant_d;
  req_id_t          owner_q, owner_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             we_q, we_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [31:0]      if_rdata_q, if_rdata_d;
  logic [31:0]      d_rdata_q, d_rdata_d;

  logic             grant_valid;
  req_id_t          grant_id;

  rr_arb2 u_rr (
    .req_if      (if_req),
    .req_d       (d_req),
    .last_grant  (last_grant_q),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= REQ_IF;
      owner_q      <= REQ_IF;
      cnt_q        <= '0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      if_rdata_q   <= '0;
      d_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      cnt_q        <= cnt_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      if_rdata_q   <= if_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    cnt_d        = cnt_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    if_rdata_d   = if_rdata_q;
    d_rdata_d    = d_rdata_q;
    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          owner_d      = grant_id;
          last_grant_d = grant_id;
          cnt_d        = CNT_W'(WAIT_CYCLES);
          state_d      = ACCESS;
          if (grant_id == REQ_D) begin
            addr_d  = d_addr;
            wdata_d = d_wdata;
            we_d    = d_we;
          end else begin
            // Fetch never writes; wdata keeps its previous value.
            addr_d = if_addr;
            we_d   = 1'b0;
          end
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          state_d = DONE;
          if (!we_q) begin
            if (owner_q == REQ_D) d_rdata_d  = mem_rd;
            else                  if_rdata_d = mem_rd;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Write strobe is combinational from state so a reset removes it at once.
  assign mem_we   = (state_q == ACCESS) && (cnt_q == '0) && we_q;
  assign mem_a    = addr_q;
  assign mem_wd   = wdata_q;
  assign if_ready = (state_q == DONE) && (owner_q == REQ_IF);
  assign d_ready  = (state_q == DONE) && (owner_q == REQ_D);
  assign if_rdata = if_rdata_q;
  assign d_rdata  = d_rdata_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: four instances (WAIT_CYCLES 1, 0, 15, 3),
// each with its own word-addressed memory model.
module tb_mem_arbiter;

  localparam int NI = 4;

  logic                    clk = 1'b0;
  logic                    mem_init;
  logic [NI-1:0]           rst, if_req, d_req, d_we;
  logic [NI-1:0]           if_ready, d_ready, mem_we, busy;
  logic [NI-1:0][31:0]     if_addr, d_addr, d_wdata;
  logic [NI-1:0][31:0]     if_rdata, d_rdata, mem_a, mem_wd, mem_rd;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    logic [31:0] m [64];
    int          wc_n = 0;
    logic [31:0] wa, ww;

    mem_arbiter #(
      .WAIT_CYCLES((g == 0) ? 1 : (g == 1) ? 0 : (g == 2) ? 15 : 3)
    ) u_dut (
      .clk      (clk),
      .reset    (rst[g]),
      .if_req   (if_req[g]),
      .if_addr  (if_addr[g]),
      .if_ready (if_ready[g]),
      .if_rdata (if_rdata[g]),
      .d_req    (d_req[g]),
      .d_we     (d_we[g]),
      .d_addr   (d_addr[g]),
      .d_wdata  (d_wdata[g]),
      .d_ready  (d_ready[g]),
      .d_rdata  (d_rdata[g]),
      .mem_we   (mem_we[g]),
      .mem_a    (mem_a[g]),
      .mem_wd   (mem_wd[g]),
      .mem_rd   (mem_rd[g]),
      .busy     (busy[g])
    );

    assign mem_rd[g] = m[mem_a[g][7:2]];

    always @(posedge clk) begin
      if (mem_init) begin
        for (int i = 0; i < 64; i++)
          m[i] <= (i == 2) ? 32'h20020005 : (i == 4) ? 32'h11111111 : 32'h0;
      end else if (mem_we[g]) begin
        m[mem_a[g][7:2]] <= mem_wd[g];
      end
    end

    // Count committed writes and remember the last one.
    always @(posedge clk) begin
      if (mem_we[g]) begin
        wc_n <= wc_n + 1;
        wa   <= mem_a[g];
        ww   <= mem_wd[g];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Step negedges until instance g raises a ready; n = cycles waited, -1 on timeout.
  task automatic wait_rdy(input int g, input bit cb, output int n);
    int bad;
    bad = 0;
    n   = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (busy[g] !== 1'b1) bad++;
      if (if_ready[g] || d_ready[g]) begin
        n = k;
        break;
      end
    end
    if (cb) chk("busy_during_access", bad, 0);
  endtask

  initial begin
    int n;
    logic seen;
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic seen;
    rst = '1; mem_init = 1'b1;
    if_req = '0; d_req = '0; d_we = '0;
    if_addr = '0; d_addr = '0; d_wdata = '0;
    repeat (2) @(negedge clk);
    for (int g = 0; g < NI; g++) begin
      chk("reset_ctrl", {28'd0, if_ready[g], d_ready[g], mem_we[g], busy[g]}, 32'd0);
      chk("reset_data", mem_a[g] | mem_wd[g] | if_rdata[g] | d_rdata[g], 32'd0);
    end
    rst = '0; mem_init = 1'b0;
    @(negedge clk);

    // Fetch from 0x8, WAIT_CYCLES=1.
    chk("idle_busy_c0", busy[0], 0);
    if_addr[0] = 32'h8; if_req[0] = 1'b1;
    wait_rdy(0, 1'b1, n);
    if_req[0] = 1'b0;
    chk("if_latency", n, 3);
    chk("if_is_fetch", if_ready[0], 1);
    chk("if_rdata", if_rdata[0], 32'h20020005);
    repeat (3) @(negedge clk);
    chk("if_rdata_hold", if_rdata[0], 32'h20020005);
    chk("if_no_write", g_dut[0].wc_n, 0);
    chk("if_back_idle", busy[0], 0);

    // Store 0xDEADBEEF to 0x54, then load it back.
    d_addr[0] = 32'h54; d_wdata[0] = 32'hDEADBEEF; d_we[0] = 1'b1; d_req[0] = 1'b1;
    wait_rdy(0, 1'b1, n);
    d_req[0] = 1'b0; d_we[0] = 1'b0;
    chk("st_latency", n, 3);
    chk("st_we_once", g_dut[0].wc_n, 1);
    chk("st_mem_a", g_dut[0].wa, 32'h54);
    chk("st_mem_wd", g_dut[0].ww, 32'hDEADBEEF);
    @(negedge clk);
    d_req[0] = 1'b1;
    wait_rdy(0, 1'b1, n);
    d_req[0] = 1'b0;
    chk("ld_latency", n, 3);
    chk("ld_rdata", d_rdata[0], 32'hDEADBEEF);
    chk("ld_if_untouched", if_rdata[0], 32'h20020005);
    chk("ld_no_write", g_dut[0].wc_n, 1);

    // Fresh reset, both request together and hold: D, IF, D, IF.
    @(negedge clk);
    rst[0] = 1'b1;
    @(negedge clk);
    rst[0] = 1'b0;
    @(negedge clk);
    if_addr[0] = 32'h8; d_addr[0] = 32'h54; d_we[0] = 1'b0;
    if_req[0] = 1'b1; d_req[0] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_rdy(0, 1'b0, n);
      chk("rr_spacing", n, (k == 0) ? 3 : 4);
      chk("rr_winner_d", d_ready[0], (k % 2 == 0) ? 1 : 0);
    end
    if_req[0] = 1'b0; d_req[0] = 1'b0;
    chk("rr_d_rdata", d_rdata[0], 32'hDEADBEEF);
    chk("rr_if_rdata", if_rdata[0], 32'h20020005);

    // WAIT_CYCLES=0 and 15 single loads from 0x8.
    for (int g = 1; g <= 2; g++) begin
      chk("wc_busy_c0", busy[g], 0);
      d_addr[g] = 32'h8; d_req[g] = 1'b1;
      wait_rdy(g, 1'b1, n);
      d_req[g] = 1'b0;
      chk("wc_latency", n, (g == 1) ? 2 : 17);
      chk("wc_rdata", d_rdata[g], 32'h20020005);
      @(negedge clk);
      chk("wc_busy_after", busy[g], 0);
    end

    // WAIT_CYCLES=3: reset during ACCESS of a store to 0x10.
    d_addr[3] = 32'h10; d_wdata[3] = 32'hCAFEF00D; d_we[3] = 1'b1; d_req[3] = 1'b1;
    @(negedge clk);
    chk("abort_busy_c1", busy[3], 1);
    @(negedge clk);
    chk("abort_we_c2", mem_we[3], 0);
    rst[3] = 1'b1; d_req[3] = 1'b0; d_we[3] = 1'b0;
    #1;
    chk("abort_idle_now", busy[3], 0);
    chk("abort_we_now", mem_we[3], 0);
    seen = 1'b0;
    repeat (2) begin @(negedge clk); seen |= d_ready[3]; end
    rst[3] = 1'b0;
    repeat (6) begin @(negedge clk); seen |= d_ready[3] | busy[3]; end
    chk("abort_no_ready", seen, 0);
    chk("abort_no_write", g_dut[3].wc_n, 0);
    chk("abort_mem_kept", g_dut[3].m[4], 32'h11111111);
    d_addr[3] = 32'h10; d_req[3] = 1'b1;
    wait_rdy(3, 1'b1, n);
    d_req[3] = 1'b0;
    chk("abort_reload_lat", n, 5);
    chk("abort_reload_data", d_rdata[3], 32'h11111111);

    // d_req dropped after grant; held if_req served next.
    @(negedge clk);
    d_addr[0] = 32'h60; d_wdata[0] = 32'h12345678; d_we[0] = 1'b1;
    if_addr[0] = 32'h54;
    d_req[0] = 1'b1; if_req[0] = 1'b1;
    @(negedge clk);
    d_req[0] = 1'b0; d_we[0] = 1'b0;
    wait_rdy(0, 1'b1, n);
    chk("drop_d_latency", n, 2);
    chk("drop_d_ready", d_ready[0], 1);
    wait_rdy(0, 1'b0, n);
    if_req[0] = 1'b0;
    chk("drop_if_latency", n, 4);
    chk("drop_if_ready", if_ready[0], 1);
    chk("drop_write_done", g_dut[0].m[24], 32'h12345678);
    chk("drop_if_rdata", if_rdata[0], 32'hDEADBEEF);
    chk("drop_d_rdata_kept", d_rdata[0], 32'hDEADBEEF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
